// File: rtl/tim_arbiter.sv
// rtl/tim_arbiter.sv - two-requester arbiter in front of the single tim port
//
// Purpose: shares one 1-cycle-latency tim port between instruction fetch (imem)
// and data load/store (dmem). Each cycle picks one candidate, drives it onto
// tim_*, parks the loser in a one-entry pending slot, and steers the tim
// response back to whichever port owned the previous cycle's request.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   imem_valid/addr              fetch request pulse and byte address
//   imem_rdata/ready             fetch response pulse and data
//   dmem_valid/addr/wdata/wstrb  data request pulse (wstrb==0 means load)
//   dmem_rdata/ready             data response pulse and data
//   tim_valid/instr/addr/wdata/wstrb  request to tim (instr=1 for fetch)
//   tim_rdata/ready              tim response, one cycle after tim_valid
//
// Parameter arb_mode: 0 = round-robin on conflict, 1 = data port always wins.

module tim_arbiter #(
    parameter int unsigned arb_mode = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        tim_valid,
    output logic        tim_instr,
    output logic [31:0] tim_addr,
    output logic [31:0] tim_wdata,
    output logic [3:0]  tim_wstrb,
    input  logic [31:0] tim_rdata,
    input  logic        tim_ready
);

    typedef enum logic { PORT_D = 1'b0, PORT_I = 1'b1 } port_e;

    // Pending slots hold a request that lost arbitration in its issue cycle.
    logic        pi_full;
    logic [31:0] pi_addr;
    logic        pd_full;
    logic [31:0] pd_addr;
    logic [31:0] pd_wdata;
    logic [3:0]  pd_wstrb;

    // Per-port outstanding flag: set on an accepted request, cleared by its ready.
    logic        i_out;
    logic        d_out;

    port_e       last_grant;
    logic        own_valid;
    port_e       own_port;

    logic        i_busy, d_busy;
    logic        i_new, d_new;
    logic        i_cand, d_cand;
    logic        data_first;
    logic        grant_i, grant_d;
    logic        resp_ok;

    // A port may issue again in the same cycle its ready pulses.
    assign i_busy = i_out && !imem_ready;
    assign d_busy = d_out && !dmem_ready;
    assign i_new  = imem_valid && !i_busy;
    assign d_new  = dmem_valid && !d_busy;

    assign i_cand = i_new || pi_full;
    assign d_cand = d_new || pd_full;

    assign data_first = (arb_mode != 0) || (last_grant == PORT_I);
    assign grant_d    = d_cand && (!i_cand || data_first);
    assign grant_i    = i_cand && !grant_d;

    always_comb begin
        tim_valid = 1'b0;
        tim_instr = 1'b0;
        tim_addr  = '0;
        tim_wdata = '0;
        tim_wstrb = '0;
        if (reset) begin
            if (grant_i) begin
                tim_valid = 1'b1;
                tim_instr = 1'b1;
                tim_addr  = pi_full ? pi_addr : imem_addr;
            end else if (grant_d) begin
                tim_valid = 1'b1;
                tim_addr  = pd_full ? pd_addr  : dmem_addr;
                tim_wdata = pd_full ? pd_wdata : dmem_wdata;
                tim_wstrb = pd_full ? pd_wstrb : dmem_wstrb;
            end
        end
    end

    // Owner is cleared asynchronously, so a tim_ready in the first cycle after
    // reset release finds no owner and is dropped.
    assign resp_ok    = reset && tim_ready && own_valid;
    assign imem_ready = resp_ok && (own_port == PORT_I);
    assign dmem_ready = resp_ok && (own_port == PORT_D);
    assign imem_rdata = imem_ready ? tim_rdata : 32'h0;
    assign dmem_rdata = dmem_ready ? tim_rdata : 32'h0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pi_full    <= 1'b0;
            pi_addr    <= '0;
            pd_full    <= 1'b0;
            pd_addr    <= '0;
            pd_wdata   <= '0;
            pd_wstrb   <= '0;
            i_out      <= 1'b0;
            d_out      <= 1'b0;
            last_grant <= PORT_D;
            own_valid  <= 1'b0;
            own_port   <= PORT_D;
        end else begin
            own_valid <= grant_i || grant_d;
            own_port  <= grant_i ? PORT_I : PORT_D;
            if (grant_i || grant_d) begin
                last_grant <= grant_i ? PORT_I : PORT_D;
            end

            // A full slot implies the port is busy, so a slot and a fresh
            // request never compete within the same port.
            if (grant_i) begin
                pi_full <= 1'b0;
            end else if (i_new) begin
                pi_full <= 1'b1;
                pi_addr <= imem_addr;
            end

            if (grant_d) begin
                pd_full <= 1'b0;
            end else if (d_new) begin
                pd_full  <= 1'b1;
                pd_addr  <= dmem_addr;
                pd_wdata <= dmem_wdata;
                pd_wstrb <= dmem_wstrb;
            end

            if (i_new) begin
                i_out <= 1'b1;
            end else if (imem_ready) begin
                i_out <= 1'b0;
            end

            if (d_new) begin
                d_out <= 1'b1;
            end else if (dmem_ready) begin
                d_out <= 1'b0;
            end
        end
    end

    a_imem_one_outstanding: assert property (@(posedge clock) disable iff (!reset)
        !(imem_valid && i_busy));
    a_dmem_one_outstanding: assert property (@(posedge clock) disable iff (!reset)
        !(dmem_valid && d_busy));

endmodule

// File: tb/tb_tim_arbiter.sv
// tb/tb_tim_arbiter.sv - self-checking bench for tim_arbiter

module tb_tim_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        imem_valid, dmem_valid, imem_valid1, dmem_valid1;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;

    logic [31:0] imem_rdata_0, dmem_rdata_0, tim_addr_0, tim_wdata_0, tim_rdata_0;
    logic        imem_ready_0, dmem_ready_0, tim_valid_0, tim_instr_0, tim_ready_0;
    logic [3:0]  tim_wstrb_0;
    logic [31:0] imem_rdata_1, dmem_rdata_1, tim_addr_1, tim_wdata_1, tim_rdata_1;
    logic        imem_ready_1, dmem_ready_1, tim_valid_1, tim_instr_1, tim_ready_1;
    logic [3:0]  tim_wstrb_1;

    tim_arbiter #(.arb_mode(0)) u0 (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata_0), .imem_ready(imem_ready_0),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata_0), .dmem_ready(dmem_ready_0),
        .tim_valid(tim_valid_0), .tim_instr(tim_instr_0), .tim_addr(tim_addr_0),
        .tim_wdata(tim_wdata_0), .tim_wstrb(tim_wstrb_0),
        .tim_rdata(tim_rdata_0), .tim_ready(tim_ready_0)
    );

    tim_arbiter #(.arb_mode(1)) u1 (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid1), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata_1), .imem_ready(imem_ready_1),
        .dmem_valid(dmem_valid1), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata_1), .dmem_ready(dmem_ready_1),
        .tim_valid(tim_valid_1), .tim_instr(tim_instr_1), .tim_addr(tim_addr_1),
        .tim_wdata(tim_wdata_1), .tim_wstrb(tim_wstrb_1),
        .tim_rdata(tim_rdata_1), .tim_ready(tim_ready_1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic quiet = 1'b0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory contents: unwritten words read back as a pattern of their address.
    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    logic [31:0] mem0    [logic [31:0]];
    logic [31:0] mem1    [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] rd0(input logic [31:0] a);
        return mem0.exists(a) ? mem0[a] : mem_default(a);
    endfunction
    function automatic logic [31:0] rd1(input logic [31:0] a);
        return mem1.exists(a) ? mem1[a] : mem_default(a);
    endfunction
    function automatic logic [31:0] rdref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    // tim models: respond one cycle after tim_valid; stores return 0.
    logic        tr0 = 1'b0, tr1 = 1'b0, inj0 = 1'b0;
    logic [31:0] trd0 = '0, trd1 = '0;
    always @(posedge clock) begin
        tr0  <= tim_valid_0;
        trd0 <= 32'h0;
        if (tim_valid_0) begin
            if (tim_wstrb_0 != 4'h0) mem0[tim_addr_0] = merge(rd0(tim_addr_0), tim_wdata_0, tim_wstrb_0);
            else trd0 <= rd0(tim_addr_0);
        end
    end
    always @(posedge clock) begin
        tr1  <= tim_valid_1;
        trd1 <= 32'h0;
        if (tim_valid_1) begin
            if (tim_wstrb_1 != 4'h0) mem1[tim_addr_1] = merge(rd1(tim_addr_1), tim_wdata_1, tim_wstrb_1);
            else trd1 <= rd1(tim_addr_1);
        end
    end
    assign tim_ready_0 = tr0 | inj0;
    assign tim_rdata_0 = inj0 ? 32'hBAD0_0001 : trd0;
    assign tim_ready_1 = tr1;
    assign tim_rdata_1 = trd1;

    // Scoreboard: expected responses queued at issue, popped on ready.
    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t exp_i[$];
    exp_t exp_d[$];

    task automatic exp_fetch(input logic [31:0] a, input int lat);
        exp_t e;
        e.data = rdref(a);
        e.due  = cyc + lat;
        exp_i.push_back(e);
    endtask

    task automatic exp_data(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                            input int lat);
        exp_t e;
        if (s != 4'h0) begin
            ref_mem[a] = merge(rdref(a), w, s);
            e.data = 32'h0;
        end else begin
            e.data = rdref(a);
        end
        e.due = cyc + lat;
        exp_d.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (imem_ready_0) begin
            if (exp_i.size() == 0) chk("imem_unexpected_ready", {31'h0, imem_ready_0}, 32'h0);
            else begin
                e = exp_i.pop_front();
                chk("imem_rdata", imem_rdata_0, e.data);
                chk("imem_latency", cyc, e.due);
                chk("dmem_ready_idle", {31'h0, dmem_ready_0}, 32'h0);
            end
        end
        if (dmem_ready_0) begin
            if (exp_d.size() == 0) chk("dmem_unexpected_ready", {31'h0, dmem_ready_0}, 32'h0);
            else begin
                e = exp_d.pop_front();
                chk("dmem_rdata", dmem_rdata_0, e.data);
                chk("dmem_latency", cyc, e.due);
            end
        end
        if (quiet) chk("quiet_tim_valid", {31'h0, tim_valid_0}, 32'h0);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                         input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds);
        imem_valid = iv;
        imem_addr  = ia;
        dmem_valid = dv;
        dmem_addr  = da;
        dmem_wdata = dw;
        dmem_wstrb = ds;
    endtask

    task automatic check_drained(input string nm);
        chk({nm, "_imem_drained"}, exp_i.size(), 32'h0);
        chk({nm, "_dmem_drained"}, exp_d.size(), 32'h0);
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ds;
        int          ilat;
        int          dlat;
        logic        ex_instr;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vecs[0] = '{1'b1, 32'h10, 1'b0, 32'h0,  32'h0,        4'h0, 1, 0, 1'b1};
        vecs[1] = '{1'b0, 32'h0,  1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1, 1'b0};
        vecs[2] = '{1'b0, 32'h0,  1'b1, 32'h20, 32'h0,        4'h0, 0, 1, 1'b0};
        vecs[3] = '{1'b1, 32'h44, 1'b1, 32'h20, 32'h0,        4'h0, 1, 2, 1'b1};
        vecs[4] = '{1'b1, 32'h48, 1'b1, 32'h24, 32'hCAFEF00D, 4'h3, 1, 2, 1'b1};
        vecs[5] = '{1'b0, 32'h0,  1'b1, 32'h24, 32'h0,        4'h0, 0, 1, 1'b0};
        vecs[6] = '{1'b1, 32'h50, 1'b0, 32'h0,  32'h0,        4'h0, 1, 0, 1'b1};
        vecs[7] = '{1'b1, 32'h54, 1'b1, 32'h10, 32'h0,        4'h0, 2, 1, 1'b0};

        mem0[32'h10]    = 32'hDEADBEEF;
        ref_mem[32'h10] = 32'hDEADBEEF;

        // Reset with both requesters active: every output held at zero.
        reset = 1'b0;
        drive(1'b1, 32'h1234, 1'b1, 32'h5678, 32'hFFFF_FFFF, 4'hF);
        imem_valid1 = 1'b1;
        dmem_valid1 = 1'b1;
        step();
        step();
        @(negedge clock);
        chk("rst_tim_valid", {31'h0, tim_valid_0}, 32'h0);
        chk("rst_tim_instr", {31'h0, tim_instr_0}, 32'h0);
        chk("rst_tim_addr", tim_addr_0, 32'h0);
        chk("rst_tim_wdata", tim_wdata_0, 32'h0);
        chk("rst_tim_wstrb", {28'h0, tim_wstrb_0}, 32'h0);
        chk("rst_readies", {30'h0, imem_ready_0, dmem_ready_0}, 32'h0);
        chk("rst_tim_valid_m1", {31'h0, tim_valid_1}, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        imem_valid1 = 1'b0;
        dmem_valid1 = 1'b0;
        reset = 1'b1;
        quiet = 1'b1;
        repeat (3) step();
        quiet = 1'b0;

        // Table-driven single-shot vectors through the round-robin instance.
        for (int k = 0; k < NV; k++) begin
            v = vecs[k];
            drive(v.iv, v.ia, v.dv, v.da, v.dw, v.ds);
            if (v.iv) exp_fetch(v.ia, v.ilat);
            if (v.dv) exp_data(v.da, v.dw, v.ds, v.dlat);
            @(negedge clock);
            chk("vec_tim_valid", {31'h0, tim_valid_0}, 32'h1);
            chk("vec_tim_instr", {31'h0, tim_instr_0}, {31'h0, v.ex_instr});
            chk("vec_tim_addr", tim_addr_0, v.ex_instr ? v.ia : v.da);
            chk("vec_tim_wdata", tim_wdata_0, v.ex_instr ? 32'h0 : v.dw);
            chk("vec_tim_wstrb", {28'h0, tim_wstrb_0}, v.ex_instr ? 32'h0 : {28'h0, v.ds});
            step();
            drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
            repeat (3) step();
            check_drained("vec");
        end

        // Back-to-back conflicts: last grant was instr, so data wins first,
        // then the pending fetch beats a fresh data request issued on its ready.
        drive(1'b1, 32'h60, 1'b1, 32'h24, 32'h0, 4'h0);
        exp_fetch(32'h60, 2);
        exp_data(32'h24, 32'h0, 4'h0, 1);
        @(negedge clock);
        chk("b2b_n_instr", {31'h0, tim_instr_0}, 32'h0);
        chk("b2b_n_addr", tim_addr_0, 32'h24);
        step();
        drive(1'b0, 32'h0, 1'b1, 32'h20, 32'h0, 4'h0);
        exp_data(32'h20, 32'h0, 4'h0, 2);
        @(negedge clock);
        chk("b2b_n1_instr", {31'h0, tim_instr_0}, 32'h1);
        chk("b2b_n1_addr", tim_addr_0, 32'h60);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clock);
        chk("b2b_n2_valid", {31'h0, tim_valid_0}, 32'h1);
        chk("b2b_n2_instr", {31'h0, tim_instr_0}, 32'h0);
        chk("b2b_n2_addr", tim_addr_0, 32'h20);
        repeat (3) step();
        check_drained("b2b");

        // Fixed-priority instance: data wins every conflict.
        for (int r = 0; r < 3; r++) begin
            imem_addr   = 32'h80 + 32'(r * 4);
            dmem_addr   = 32'h90 + 32'(r * 4);
            dmem_wdata  = 32'h0;
            dmem_wstrb  = 4'h0;
            imem_valid1 = 1'b1;
            dmem_valid1 = 1'b1;
            @(negedge clock);
            chk("fp_n_instr", {31'h0, tim_instr_1}, 32'h0);
            chk("fp_n_addr", tim_addr_1, 32'h90 + 32'(r * 4));
            step();
            imem_valid1 = 1'b0;
            dmem_valid1 = 1'b0;
            @(negedge clock);
            chk("fp_n1_instr", {31'h0, tim_instr_1}, 32'h1);
            chk("fp_n1_addr", tim_addr_1, 32'h80 + 32'(r * 4));
            chk("fp_n1_dready", {31'h0, dmem_ready_1}, 32'h1);
            chk("fp_n1_drdata", dmem_rdata_1, mem_default(32'h90 + 32'(r * 4)));
            chk("fp_n1_iready", {31'h0, imem_ready_1}, 32'h0);
            step();
            @(negedge clock);
            chk("fp_n2_iready", {31'h0, imem_ready_1}, 32'h1);
            chk("fp_n2_irdata", imem_rdata_1, mem_default(32'h80 + 32'(r * 4)));
            chk("fp_n2_dready", {31'h0, dmem_ready_1}, 32'h0);
            step();
            step();
        end

        // Reset mid-flight: fetch granted, data pending, reset before response.
        drive(1'b1, 32'h70, 1'b1, 32'h20, 32'h0, 4'h0);
        @(negedge clock);
        chk("mid_instr_granted", {31'h0, tim_instr_0}, 32'h1);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset = 1'b0;
        quiet = 1'b1;
        @(negedge clock);
        chk("mid_iready", {31'h0, imem_ready_0}, 32'h0);
        chk("mid_dready", {31'h0, dmem_ready_0}, 32'h0);
        step();
        step();
        reset = 1'b1;
        inj0  = 1'b1;
        @(negedge clock);
        chk("post_rst_iready", {31'h0, imem_ready_0}, 32'h0);
        chk("post_rst_dready", {31'h0, dmem_ready_0}, 32'h0);
        step();
        inj0 = 1'b0;
        repeat (4) step();
        quiet = 1'b0;
        drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_fetch(32'h10, 1);
        @(negedge clock);
        chk("post_rst_fetch_instr", {31'h0, tim_instr_0}, 32'h1);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) step();
        check_drained("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tim_arbiter.md
Name: tim_arbiter

Overview:
- Shares the single tightly-integrated memory (tim) port between the instruction-fetch requester and the data load/store requester.
- Arbitrates each cycle and drives the granted request onto the tim port.
- Holds the losing request in a one-entry pending slot until it is granted.
- Routes the 1-cycle tim response back to the requester that issued it.
- Sits between the core's fetch/LSU ports and tim.

Parameters:
arb_mode, 0, 0 = round-robin between ports on conflict; 1 = fixed priority, data port always wins
- Address and data widths are fixed at 32 bits; strobe width is fixed at 4 bits.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (reset==0 holds block in reset)
imem_valid  input  1  instruction fetch request pulse
imem_addr  input  32  fetch byte address
imem_rdata  output  32  fetch read data
imem_ready  output  1  fetch response pulse
dmem_valid  input  1  data request pulse
dmem_addr  input  32  data byte address
dmem_wdata  input  32  store data
dmem_wstrb  input  4  byte strobes; 0 = load
dmem_rdata  output  32  load data
dmem_ready  output  1  data response pulse
tim_valid  output  1  request to tim
tim_instr  output  1  1 = instruction-port request
tim_addr  output  32  request address
tim_wdata  output  32  request write data
tim_wstrb  output  4  request strobes
tim_rdata  input  32  tim read data, valid with tim_ready
tim_ready  input  1  tim response, one cycle after tim_valid

Behaviour:
Request protocol
- Requester asserts valid for exactly one cycle, with addr/wdata/wstrb valid in that cycle.
- Requester issues no new request until its ready pulse. One outstanding request per port.
- A new valid on a port whose request is still outstanding is a protocol violation: the request is ignored and a simulation assertion fires.

Candidates and grant (combinational, same cycle)
- Port candidate = incoming valid OR pending slot full.
- One candidate only: it is granted.
- Both candidates, arb_mode=0: grant the port not in last_grant.
- Both candidates, arb_mode=1: grant the data port.
- A pending slot is granted with the same rules as an incoming request. No age bias beyond round-robin.

Downstream drive
- Granted request is driven onto tim_* the same cycle; tim_valid=1.
- Instruction grant: tim_instr=1, tim_wdata=0, tim_wstrb=0.
- Data grant: tim_instr=0, with dmem fields passed through.
- No grant: all tim_* outputs = 0.
- While reset==0, all tim_* outputs are forced to 0.

State updates (rising clock edge)
- Loser's incoming request is latched into its pending slot.
- A granted pending slot is cleared.
- last_grant <= granted port.
- Owner register <= {valid=1, port=granted port}; owner cleared if no grant.

Response
- When tim_ready=1 and owner valid: tim_rdata is copied to the owner port's rdata and that port's ready pulses for 1 cycle.
- Other port: rdata=0, ready=0.
- tim_ready with owner invalid is ignored.
- Responses are combinational from registered owner plus tim inputs.

Latency and throughput
- Uncontested request: ready in cycle N+1 for valid in cycle N.
- Contested loser: ready at N+2.
- Back-to-back grants every cycle are allowed, since tim is fully pipelined at 1-cycle latency.

Reset
- Asynchronous: pending slots cleared, owner cleared, last_grant = data (so the first round-robin conflict goes to instruction).
- All outputs 0 during reset.
- Reset mid-operation drops the in-flight response and pending requests. A tim_ready arriving in the first cycle after reset release is ignored.

Test Plan:
1. Reset: hold reset=0 with imem_valid=dmem_valid=1 → all outputs 0. Release reset → no ready pulses appear.
2. Uncontested fetch: imem_valid, addr=0x00000010, tim returns 0xDEADBEEF → tim_valid=1, tim_instr=1, wstrb=0 in cycle N; imem_ready=1, imem_rdata=0xDEADBEEF in N+1; dmem_ready=0.
3. Store then load: dmem store addr 0x20, wdata 0x11223344, wstrb 0xF; load 0x20 two cycles later → tim sees store with wstrb=0xF; load returns 0x11223344 on dmem_rdata; each dmem_ready is 1 cycle.
4. Conflict, arb_mode=0: both valid in cycle N after reset → instr granted at N, data at N+1 from pending slot; imem_ready at N+1, dmem_ready at N+2. Repeat conflict → data wins first.
5. Conflict, arb_mode=1: both valid in cycle N → data granted at N, instr at N+1, on every repeat.
6. Reset mid-flight: grant a fetch, assert reset=0 in cycle N+1 before tim_ready is sampled → imem_ready stays 0. Pending data slot is cleared with no later tim_valid.
